// File: rtl/regfile_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cmd_master
// Brief    : Command-driven initiator for a 16x16 register file (LOAD/ADD/MOVE/READ)
// Revision : 1.0
// ============================================================================

module regfile_cmd_master #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              en,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_ADD  = 2'b01;
    localparam logic [1:0] c_OP_MOVE = 2'b10;
    localparam logic [1:0] c_OP_READ = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic [ADDR_W-1:0] r_ra1;
    logic [ADDR_W-1:0] r_ra2;
    logic [DATA_W-1:0] r_rsp_data;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_accept;
    logic              w_fetch;
    logic              w_write;
    logic              w_resp;
    logic [DATA_W-1:0] w_wd_calc;

    // Strobes are gated by rst so an in-flight write is dropped the moment rst rises.
    assign cmd_ready = (r_state == c_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_fetch   = (r_state == c_FETCH);
    assign w_write   = (r_state == c_WRITE) && !rst;
    assign w_resp    = (r_state == c_RESP) && !rst;

    always_comb begin
        w_wd_calc = r_op_a;
        case (r_op)
            c_OP_LOAD: w_wd_calc = r_imm;
            c_OP_ADD:  w_wd_calc = r_op_a + r_op_b;
            default:   w_wd_calc = r_op_a;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (cmd_op == c_OP_LOAD) ? c_WRITE : c_FETCH;
                end
            end
            c_FETCH: w_state_nxt = (r_op == c_OP_READ) ? c_RESP : c_WRITE;
            c_WRITE: w_state_nxt = c_IDLE;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_rd  <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= cmd_op;
            r_rs1 <= cmd_rs1;
            r_rs2 <= cmd_rs2;
            r_rd  <= cmd_rd;
            r_imm <= cmd_imm;
        end
    end

    // Operands are sampled before any write, so rd may alias rs1/rs2 safely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_ra1  <= '0;
            r_ra2  <= '0;
        end else if (w_fetch) begin
            r_op_a <= rd1;
            r_op_b <= rd2;
            r_ra1  <= r_rs1;
            r_ra2  <= r_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_write) begin
            r_wa <= r_rd;
            r_wd <= w_wd_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_op_count <= '0;
        end else if (rsp_valid) begin
            r_rsp_data <= rsp_data;
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    // Address/data outputs follow the live value in their active state and hold otherwise.
    assign ra1       = w_fetch ? r_rs1 : r_ra1;
    assign ra2       = w_fetch ? r_rs2 : r_ra2;
    assign en        = w_write;
    assign wa        = w_write ? r_rd : r_wa;
    assign wd        = w_write ? w_wd_calc : r_wd;
    assign rsp_valid = w_write || w_resp;
    assign rsp_data  = w_write ? w_wd_calc : (w_resp ? r_op_a : r_rsp_data);
    assign op_count  = r_op_count;

endmodule

`default_nettype wire
